vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/vga_sync_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the sync-lock FSM encoding,
// used by both the sync generators and the decoder.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;

  localparam int               CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit; both stages reset to
// the idle (high) sync level so reset never fakes a sync edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic iclock,
  input  logic ireset_n,
  input  logic id,
  output logic oq
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= id;
      sync_q <= meta_q;
    end
  end

  assign oq = sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a lock indication from a VGA hsync/vsync
// stream, and samples the colour at one probe coordinate.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic       iclock,
  input  logic       ireset_n,
  input  logic       ihsync,
  input  logic       ivsync,
  input  logic       ivga_r,
  input  logic       ivga_g,
  input  logic       ivga_b,
  input  logic [9:0] iprobe_x,
  input  logic [9:0] iprobe_y,
  output logic [9:0] ox,
  output logic [9:0] oy,
  output logic       ode,
  output logic       olocked,
  output logic [2:0] oprobe_rgb,
  output logic       oprobe_valid,
  output logic       oerr,
  output logic [9:0] oline_len
);

  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_START   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END     = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_START   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END     = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  // All five pins share one synchronizer depth so sync and colour stay aligned.
  logic [4:0] pins_raw;
  logic [4:0] pins_s;
  assign pins_raw = {ihsync, ivsync, ivga_r, ivga_g, ivga_b};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .iclock   (iclock),
      .ireset_n (ireset_n),
      .id       (pins_raw[i]),
      .oq       (pins_s[i])
    );
  end

  logic       hsync_s, vsync_s;
  logic [2:0] rgb_s;
  assign hsync_s = pins_s[4];
  assign vsync_s = pins_s[3];
  assign rgb_s   = pins_s[2:0];

  sync_state_e      state_q;
  logic             line_bad_q, locked_q, err_q;
  logic             hsync_prev_q, hsync_prev_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [2:0]       rgb_q, rgb_d;
  logic [9:0]       ox_q, ox_d, oy_q, oy_d;
  logic             ode_q, ode_d;
  logic [2:0]       probe_rgb_q, probe_rgb_d;
  logic             probe_valid_q, probe_valid_d;

  logic             hfall, vfall, frame_start;
  logic [CNT_W-1:0] line_len, vcnt_inc;
  logic             len_bad, frame_bad, hsync_lost, active, probe_hit;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    hsync_prev_d = hsync_s;
    vsync_prev_d = vsync_s;
    rgb_d        = rgb_s;

    hfall       = hsync_prev_q & ~hsync_s;
    vfall       = vsync_prev_q & ~vsync_s;
    frame_start = hfall & (pend_q | vfall);
    line_len    = hcnt_q + 1'b1;
    vcnt_inc    = vcnt_q + 1'b1;
    len_bad     = hfall && (line_len != H_TOTAL_C);
    hsync_lost  = (hcnt_q == CNT_MAX);
    // Short frame seen at its frame start; long frame seen at line V_TOTAL.
    frame_bad   = (frame_start && (vcnt_inc != V_TOTAL_C)) ||
                  (hfall && !frame_start && (vcnt_inc == V_TOTAL_C));

    hcnt_d     = hfall ? '0 : (hsync_lost ? CNT_MAX : hcnt_q + 1'b1);
    line_len_d = hfall ? line_len : line_len_q;

    pend_d = pend_q;
    if (hfall)      pend_d = 1'b0;
    else if (vfall) pend_d = 1'b1;

    vcnt_d = vcnt_q;
    if (frame_start) vcnt_d = '0;
    else if (hfall)  vcnt_d = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_inc;

    active = (hcnt_q >= H_START) && (hcnt_q < H_END) &&
             (vcnt_q >= V_START) && (vcnt_q < V_END);
    ox_d   = active ? hcnt_q - H_START : ox_q;
    oy_d   = active ? vcnt_q - V_START : oy_q;
    ode_d  = active && (state_q == LOCKED);

    probe_hit     = ode_d && (ox_d == iprobe_x) && (oy_d == iprobe_y);
    probe_valid_d = probe_hit;
    probe_rgb_d   = probe_hit ? rgb_q : probe_rgb_q;
  end

  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      hsync_prev_q  <= 1'b1;
      vsync_prev_q  <= 1'b1;
      rgb_q         <= 3'b111;
      pend_q        <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      ode_q         <= 1'b0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      hsync_prev_q  <= hsync_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      rgb_q         <= rgb_d;
      pend_q        <= pend_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      ode_q         <= ode_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  // Lock FSM; a CHECK frame is judged including the line that ends at its
  // closing frame start.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q    <= SEARCH;
      line_bad_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (frame_start) begin
            state_q    <= CHECK;
            line_bad_q <= 1'b0;
          end
        end
        CHECK: begin
          if (frame_start) begin
            line_bad_q <= 1'b0;
            if ((vcnt_inc == V_TOTAL_C) && !line_bad_q && !len_bad) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (len_bad) begin
            line_bad_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (len_bad || frame_bad || hsync_lost) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign ox           = ox_q;
  assign oy           = oy_q;
  assign ode          = ode_q;
  assign olocked      = locked_q;
  assign oprobe_rgb   = probe_rgb_q;
  assign oprobe_valid = probe_valid_q;
  assign oerr         = err_q;
  assign oline_len    = line_len_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (40x20 clocks,
// 24x12 active) so whole frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int H_T  = 40;
  localparam int H_S  = 4;
  localparam int H_B  = 4;
  localparam int H_A  = 24;
  localparam int V_T  = 20;
  localparam int V_S  = 2;
  localparam int V_B  = 3;
  localparam int V_A  = 12;
  localparam int H_AS = H_S + H_B;
  localparam int V_AS = V_S + V_B;
  localparam int PIX  = H_A * V_A;
  localparam int PX   = H_A - 1;
  localparam int PY   = V_A - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
  logic [9:0] probe_x = 10'(PX), probe_y = 10'(PY);
  logic [9:0] ox, oy, oline_len;
  logic       ode, olocked, oprobe_valid, oerr;
  logic [2:0] oprobe_rgb;

  vga_sync_decoder #(
    .H_TOTAL(H_T), .H_SYNC(H_S), .H_BP(H_B), .H_ACTIVE(H_A),
    .V_TOTAL(V_T), .V_SYNC(V_S), .V_BP(V_B), .V_ACTIVE(V_A)
  ) dut (
    .iclock       (clk),
    .ireset_n     (rst_n),
    .ihsync       (hs),
    .ivsync       (vs),
    .ivga_r       (r),
    .ivga_g       (g),
    .ivga_b       (b),
    .iprobe_x     (probe_x),
    .iprobe_y     (probe_y),
    .ox           (ox),
    .oy           (oy),
    .ode          (ode),
    .olocked      (olocked),
    .oprobe_rgb   (oprobe_rgb),
    .oprobe_valid (oprobe_valid),
    .oerr         (oerr),
    .oline_len    (oline_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state: expected coordinate of the pixel driven four steps ago.
  logic h_act[4];
  int   h_x[4], h_y[4];
  int   ode_cnt, pv_cnt, pv_bad, err_cnt, coord_err;
  int   frames, lock_frame, lock_delay, err_frame, err_len, err_hf_delay;
  int   since_fs, since_hf, first_x, first_y;
  logic seen_ode, prev_locked;

  initial begin
    for (int i = 0; i < 4; i++) begin
      h_act[i] = 1'b0;
      h_x[i]   = 0;
      h_y[i]   = 0;
    end
    prev_locked = 1'b0;
    since_fs    = 0;
    since_hf    = 0;
  end

  task automatic clear_stats();
    ode_cnt = 0; pv_cnt = 0; pv_bad = 0; err_cnt = 0; coord_err = 0;
    frames = 0; lock_frame = -1; lock_delay = -1; err_frame = -1;
    err_len = -1; err_hf_delay = -1; first_x = -1; first_y = -1;
    seen_ode = 1'b0;
  endtask

  task automatic step(input logic hs_i, input logic vs_i, input logic [2:0] rgb_i,
                      input logic act_i, input int px_i, input int py_i,
                      input logic hf_i, input logic fs_i);
    @(negedge clk);
    since_fs++;
    since_hf++;
    if (ode) begin
      ode_cnt++;
      if (!seen_ode) begin
        seen_ode = 1'b1;
        first_x  = int'(ox);
        first_y  = int'(oy);
      end
      if (!h_act[3] || int'(ox) != h_x[3] || int'(oy) != h_y[3]) coord_err++;
    end
    if (oprobe_valid) begin
      pv_cnt++;
      if (oprobe_rgb != 3'b101) pv_bad++;
    end
    if (oerr) begin
      err_cnt++;
      err_frame    = frames;
      err_len      = int'(oline_len);
      err_hf_delay = since_hf;
    end
    if (olocked && !prev_locked) begin
      lock_frame = frames;
      lock_delay = since_fs;
    end
    prev_locked = olocked;

    hs = hs_i;
    vs = vs_i;
    {r, g, b} = rgb_i;
    for (int i = 3; i > 0; i--) begin
      h_act[i] = h_act[i-1];
      h_x[i]   = h_x[i-1];
      h_y[i]   = h_y[i-1];
    end
    h_act[0] = act_i;
    h_x[0]   = px_i;
    h_y[0]   = py_i;
    if (fs_i) begin
      frames++;
      since_fs = 0;
    end
    if (hf_i) since_hf = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // One frame of nlines; line bad_v is bad_len clocks; stops early at (stop_v, stop_h).
  task automatic frame(input int nlines, input int bad_v, input int bad_len,
                       input int stop_v, input int stop_h);
    for (int v = 0; v < nlines; v++) begin
      int   len;
      int   px, py;
      logic act;
      len = (v == bad_v) ? bad_len : H_T;
      for (int h = 0; h < len; h++) begin
        if (v == stop_v && h == stop_h) return;
        px  = h - H_AS;
        py  = v - V_AS;
        act = (h >= H_AS) && (h < H_AS + H_A) && (v >= V_AS) && (v < V_AS + V_A);
        step((h < H_S) ? 1'b0 : 1'b1, (v < V_S) ? 1'b0 : 1'b1,
             (act && px == PX && py == PY) ? 3'b101 : 3'b010,
             act, px, py, h == 0, h == 0 && v == 0);
      end
    end
  endtask

  task automatic good_frames(input int n);
    for (int i = 0; i < n; i++) frame(V_T, -1, 0, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    repeat (4) @(negedge clk);
    check("rst_ox", ox, 0);
    check("rst_oy", oy, 0);
    check("rst_ode", ode, 0);
    check("rst_locked", olocked, 0);
    check("rst_rgb", oprobe_rgb, 0);
    check("rst_pvalid", oprobe_valid, 0);
    check("rst_err", oerr, 0);
    check("rst_line_len", oline_len, 0);
    rst_n = 1'b1;
    idle(10);

    // Nominal stream: lock at the 2nd frame start, two locked frames.
    clear_stats();
    good_frames(3);
    check("nom_lock_frame", lock_frame, 2);
    check("nom_lock_latency", lock_delay, 3);
    check("nom_locked", olocked, 1);
    check("nom_ode_cycles", ode_cnt, 2 * PIX);
    check("nom_first_x", first_x, 0);
    check("nom_first_y", first_y, 0);
    check("nom_coord_err", coord_err, 0);
    check("nom_probe_pulses", pv_cnt, 2);
    check("nom_probe_rgb_err", pv_bad, 0);
    check("nom_probe_rgb", oprobe_rgb, 3'b101);
    check("nom_err_pulses", err_cnt, 0);
    check("nom_line_len", oline_len, H_T);

    // One short line while locked, then relock two frame starts later.
    clear_stats();
    frame(V_T, 7, H_T - 1, -1, -1);
    check("short_err_pulses", err_cnt, 1);
    check("short_line_len", err_len, H_T - 1);
    check("short_unlocked", olocked, 0);
    good_frames(2);
    check("short_relock_frame", lock_frame, 3);
    check("short_relocked", olocked, 1);
    check("short_coord_err", coord_err, 0);

    // Hsync stuck high while locked: counter saturates, then lock drops.
    clear_stats();
    idle(1100);
    check("hlost_err_pulses", err_cnt, 1);
    check("hlost_delay", err_hf_delay, 1027);
    check("hlost_unlocked", olocked, 0);
    check("hlost_ode", ode, 0);
    check("hlost_line_len", oline_len, H_T);

    // Short frame blocks lock in CHECK; later it breaks an established lock.
    clear_stats();
    frame(V_T - 1, -1, 0, -1, -1);
    good_frames(2);
    check("vshort_lock_frame", lock_frame, 3);
    check("vshort_no_err", err_cnt, 0);
    frame(V_T - 1, -1, 0, -1, -1);
    good_frames(1);
    check("vshort_err_pulses", err_cnt, 1);
    check("vshort_err_frame", err_frame, 5);
    check("vshort_unlocked", olocked, 0);

    // Asynchronous reset mid-line while locked.
    clear_stats();
    good_frames(2);
    frame(V_T, -1, 0, 10, 20);
    check("prerst_lock_frame", lock_frame, 2);
    check("prerst_ode", ode, 1);
    check("prerst_ox", ox, 15 - H_AS);
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", olocked, 0);
    check("arst_ode", ode, 0);
    check("arst_ox", ox, 0);
    check("arst_oy", oy, 0);
    check("arst_rgb", oprobe_rgb, 0);
    check("arst_line_len", oline_len, 0);
    check("arst_err", oerr, 0);
    idle(5);
    rst_n = 1'b1;
    check("arst_err_pulses", err_cnt, 0);

    // Relock after reset; probes outside the active area never fire.
    clear_stats();
    probe_x = 10'(H_A);
    probe_y = 10'(PY);
    good_frames(3);
    probe_x = 10'd640;
    probe_y = 10'd479;
    good_frames(1);
    check("relock_frame", lock_frame, 2);
    check("relock_err_pulses", err_cnt, 0);
    check("oob_probe_pulses", pv_cnt, 0);
    check("relock_ode_cycles", ode_cnt, 3 * PIX);
    check("relock_coord_err", coord_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
